// File: rtl/sync_join4_pkg.sv
// Shared definitions for the sync_join4 four-way toggle-handshake join:
// FSM encoding, default synchronizer depth and the joined-word width helper.
package sync_join4_pkg;

   typedef enum logic {
      COLLECT  = 1'b0,
      WAIT_ACK = 1'b1
   } state_e;

   localparam int DEFAULT_SYNC_STAGES = 2;

   function automatic int join_width(input int w0, input int w1, input int w2, input int w3);
      return w0 + w1 + w2 + w3;
   endfunction

endpackage

// File: rtl/sync_join4_toggle_sync.sv
// Toggle synchronizer: brings an asynchronous two-phase request into clk and
// emits a one-cycle event for every transition seen at the last stage.
module toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_tog,
   output logic o_ev
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   ref_q, ref_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_tog};
      // The reference follows the last stage every cycle, so each event is
      // consumed on the same edge the top acts on it.
      ref_d  = sync_q[SYNC_STAGES-1];
   end

   // NOTE: sequential state uses non-blocking assignments only; mixing in
   // blocking ones here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         ref_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         ref_q  <= ref_d;
      end
   end

   assign o_ev = sync_q[SYNC_STAGES-1] ^ ref_q;

endmodule

// File: rtl/sync_join4.sv
// Four-way join: collects four bundled slices arriving on toggle channels,
// then launches their concatenation on one downstream toggle channel.
module sync_join4
   import sync_join4_pkg::*;
#(
   parameter int DATA_WIDTHIN0 = 5,
   parameter int DATA_WIDTHIN1 = 10,
   parameter int DATA_WIDTHIN2 = 3,
   parameter int DATA_WIDTHIN3 = 2,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               i_drive_4,
   input  logic [DATA_WIDTHIN0-1:0] i_data0,
   input  logic [DATA_WIDTHIN1-1:0] i_data1,
   input  logic [DATA_WIDTHIN2-1:0] i_data2,
   input  logic [DATA_WIDTHIN3-1:0] i_data3,
   output logic [3:0]               o_free_4,
   output logic                     o_driveNext,
   input  logic                     i_freeNext,
   output logic [join_width(DATA_WIDTHIN0, DATA_WIDTHIN1, DATA_WIDTHIN2, DATA_WIDTHIN3)-1:0] o_data,
   output logic                     o_overrun
);

   localparam int DW = join_width(DATA_WIDTHIN0, DATA_WIDTHIN1, DATA_WIDTHIN2, DATA_WIDTHIN3);

   logic [3:0] ev;
   logic       ev_next;

   for (genvar k = 0; k < 4; k++) begin : g_drive_sync
      toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst  (rst),
         .i_tog(i_drive_4[k]),
         .o_ev (ev[k])
      );
   end

   toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_next_sync (
      .clk  (clk),
      .rst  (rst),
      .i_tog(i_freeNext),
      .o_ev (ev_next)
   );

   logic [DATA_WIDTHIN0-1:0] slice0_q, slice0_d;
   logic [DATA_WIDTHIN1-1:0] slice1_q, slice1_d;
   logic [DATA_WIDTHIN2-1:0] slice2_q, slice2_d;
   logic [DATA_WIDTHIN3-1:0] slice3_q, slice3_d;
   logic [3:0]               full_q, full_d;
   state_e                   state_q, state_d;
   logic [3:0]               free_q, free_d;
   logic                     drive_next_q, drive_next_d;
   logic [DW-1:0]            data_q, data_d;
   logic                     overrun_q, overrun_d;
   logic                     launch;

   // NOTE: every signal gets its hold value before any condition, so no
   // path through this block can leave one unassigned and infer a latch.
   always_comb begin
      slice0_d     = slice0_q;
      slice1_d     = slice1_q;
      slice2_d     = slice2_q;
      slice3_d     = slice3_q;
      full_d       = full_q;
      state_d      = state_q;
      free_d       = free_q;
      drive_next_d = drive_next_q;
      data_d       = data_q;
      overrun_d    = overrun_q;
      launch       = (state_q == COLLECT) && (&full_q);

      for (int k = 0; k < 4; k++) begin
         if (ev[k]) begin
            if (full_q[k]) overrun_d = 1'b1;
            else           full_d[k] = 1'b1;
         end
      end
      if (ev[0] && !full_q[0]) slice0_d = i_data0;
      if (ev[1] && !full_q[1]) slice1_d = i_data1;
      if (ev[2] && !full_q[2]) slice2_d = i_data2;
      if (ev[3] && !full_q[3]) slice3_d = i_data3;

      unique case (state_q)
         COLLECT: begin
            if (ev_next) overrun_d = 1'b1;
            if (launch) begin
               // Launch-clear overrides any same-edge capture.
               data_d       = {slice0_q, slice1_q, slice2_q, slice3_q};
               drive_next_d = ~drive_next_q;
               free_d       = ~free_q;
               full_d       = '0;
               state_d      = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ev_next) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   // NOTE: slice registers are reset like the control state; they feed o_data
   // only through data_q, but clearing them keeps post-reset words deterministic.
   always_ff @(posedge clk) begin
      if (rst) begin
         slice0_q     <= '0;
         slice1_q     <= '0;
         slice2_q     <= '0;
         slice3_q     <= '0;
         full_q       <= '0;
         state_q      <= COLLECT;
         free_q       <= '0;
         drive_next_q <= 1'b0;
         data_q       <= '0;
         overrun_q    <= 1'b0;
      end else begin
         slice0_q     <= slice0_d;
         slice1_q     <= slice1_d;
         slice2_q     <= slice2_d;
         slice3_q     <= slice3_d;
         full_q       <= full_d;
         state_q      <= state_d;
         free_q       <= free_d;
         drive_next_q <= drive_next_d;
         data_q       <= data_d;
         overrun_q    <= overrun_d;
      end
   end

   assign o_free_4    = free_q;
   assign o_driveNext = drive_next_q;
   assign o_data      = data_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_sync_join4.sv
// Directed bench for sync_join4: expected words are queued when the last
// slice is driven and popped when the downstream toggle is seen.
module tb_sync_join4;
   import sync_join4_pkg::*;

   localparam int W0 = 5, W1 = 10, W2 = 3, W3 = 2;
   localparam int DW = W0 + W1 + W2 + W3;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    drv;
   logic [W0-1:0] d0;
   logic [W1-1:0] d1;
   logic [W2-1:0] d2;
   logic [W3-1:0] d3;
   logic          fnext;
   logic [3:0]    o_free_4;
   logic          o_driveNext;
   logic [DW-1:0] o_data;
   logic          o_overrun;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] sb[$];
   logic [3:0]    exp_free;
   logic          exp_dn;
   logic [DW-1:0] word_a;
   logic [W2-1:0] first_d2;

   sync_join4 #(
      .DATA_WIDTHIN0(W0), .DATA_WIDTHIN1(W1), .DATA_WIDTHIN2(W2), .DATA_WIDTHIN3(W3),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_drive_4  (drv),
      .i_data0    (d0),
      .i_data1    (d1),
      .i_data2    (d2),
      .i_data3    (d3),
      .o_free_4   (o_free_4),
      .o_driveNext(o_driveNext),
      .i_freeNext (fnext),
      .o_data     (o_data),
      .o_overrun  (o_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_idle(input string tag);
      chk($sformatf("%s_dn", tag), 32'(o_driveNext), 32'(exp_dn));
      chk($sformatf("%s_free", tag), 32'(o_free_4), 32'(exp_free));
   endtask

   task automatic expect_launch(input string tag);
      logic [DW-1:0] w;
      exp_dn   = ~exp_dn;
      exp_free = ~exp_free;
      expect_idle(tag);
      chk($sformatf("%s_sb_depth", tag), 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         w = sb.pop_front();
         chk($sformatf("%s_data", tag), 32'(o_data), 32'(w));
      end
   endtask

   task automatic ack();
      fnext = ~fnext;
      repeat (3) tick();
      expect_idle("ack_idle");
   endtask

   task automatic chk_all_zero(input string tag);
      chk($sformatf("%s_free", tag), 32'(o_free_4), 32'd0);
      chk($sformatf("%s_dn", tag), 32'(o_driveNext), 32'd0);
      chk($sformatf("%s_data", tag), 32'(o_data), 32'd0);
      chk($sformatf("%s_ovr", tag), 32'(o_overrun), 32'd0);
   endtask

   initial begin
      rst = 1'b1; drv = '0; fnext = 1'b0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      exp_free = '0; exp_dn = 1'b0;
      @(negedge clk);
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_dn", 32'(o_driveNext), 32'd0);
      end

      // Basic join: launch on the third edge after the sampling edge.
      d0 = 5'h15; d1 = 10'h2A5; d2 = 3'h6; d3 = 2'h1;
      sb.push_back({d0, d1, d2, d3});
      drv ^= 4'hF;
      repeat (3) tick();
      expect_idle("basic_early");
      tick();
      expect_launch("basic");
      chk("basic_free_all", 32'(o_free_4), 32'hF);
      ack();

      // Staggered arrival at cycles 0, 4, 9, 15.
      d0 = 5'h0A; d1 = 10'h133; d2 = 3'h1; d3 = 2'h2;
      sb.push_back({d0, d1, d2, d3});
      for (int c = 0; c <= 18; c++) begin
         case (c)
            0:  drv[0] = ~drv[0];
            4:  drv[1] = ~drv[1];
            9:  drv[2] = ~drv[2];
            15: drv[3] = ~drv[3];
            default: ;
         endcase
         tick();
         if (c < 18) expect_idle("stagger_wait");
         else        expect_launch("stagger");
      end
      ack();

      // Pipelined: word B fully collected while word A awaits its ack.
      d0 = 5'h1F; d1 = 10'h001; d2 = 3'h7; d3 = 2'h0;
      word_a = {d0, d1, d2, d3};
      sb.push_back(word_a);
      drv ^= 4'hF;
      repeat (4) tick();
      expect_launch("pipe_a");
      d0 = 5'h03; d1 = 10'h3C0; d2 = 3'h2; d3 = 2'h3;
      sb.push_back({d0, d1, d2, d3});
      drv ^= 4'hF;
      repeat (5) tick();
      expect_idle("pipe_hold");
      chk("pipe_hold_data", 32'(o_data), 32'(word_a));
      fnext = ~fnext;
      repeat (3) tick();
      expect_idle("pipe_ack_gap");
      tick();
      expect_launch("pipe_b");
      chk("pipe_b_dn_low", 32'(o_driveNext), 32'd0);
      ack();

      // Overrun: second slice-2 toggle without an intervening free.
      chk("ovr_pre", 32'(o_overrun), 32'd0);
      d2 = 3'h3; first_d2 = d2;
      drv[2] = ~drv[2];
      repeat (4) tick();
      d2 = 3'h5;
      drv[2] = ~drv[2];
      repeat (4) tick();
      chk("ovr_set", 32'(o_overrun), 32'd1);
      expect_idle("ovr_nolaunch");
      d0 = 5'h11; d1 = 10'h2F0; d3 = 2'h1;
      sb.push_back({d0, d1, first_d2, d3});
      drv ^= 4'b1011;
      repeat (4) tick();
      expect_launch("ovr_word");
      chk("ovr_sticky", 32'(o_overrun), 32'd1);
      ack();
      chk("ovr_sticky_ack", 32'(o_overrun), 32'd1);

      // Mid-operation reset in WAIT_ACK with two slots full.
      d0 = 5'h08; d1 = 10'h155; d2 = 3'h4; d3 = 2'h2;
      sb.push_back({d0, d1, d2, d3});
      drv ^= 4'hF;
      repeat (4) tick();
      expect_launch("mid_a");
      d0 = 5'h1C; d1 = 10'h0F0;
      drv ^= 4'b0011;
      repeat (4) tick();
      rst = 1'b1; drv = '0; fnext = 1'b0;
      tick();
      chk_all_zero("mid_reset");
      sb.delete();
      exp_dn = 1'b0; exp_free = '0;
      rst = 1'b0;
      repeat (2) tick();
      expect_idle("post_reset_idle");

      d0 = 5'h15; d1 = 10'h2A5; d2 = 3'h6; d3 = 2'h1;
      sb.push_back({d0, d1, d2, d3});
      drv ^= 4'hF;
      repeat (3) tick();
      expect_idle("rejoin_early");
      tick();
      expect_launch("rejoin");
      chk("rejoin_ovr", 32'(o_overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
